// File: rtl/step_scheduler.sv
// step_scheduler: BPM-driven NCO step clock walking an 8-step bar, firing double-buffered drum triggers.
module step_scheduler #(
    parameter int unsigned CLK_HZ         = 50_000_000,
    parameter int unsigned STEPS_PER_BEAT = 2,
    parameter int unsigned DEFAULT_BPM    = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] bpm,
    input  logic       ld_bpm,
    input  logic [1:0] pat_sel,
    input  logic [7:0] pat_data,
    input  logic       pat_we,
    input  logic       start,
    input  logic       pause,
    input  logic       stop,
    output logic [3:0] trig,
    output logic [2:0] step,
    output logic       bar_start,
    output logic       running
);
    localparam logic [31:0] THRESH = 32'(64'(CLK_HZ) * 64'd60 / 64'(STEPS_PER_BEAT));
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
    state_t          state, state_d;
    logic [31:0]     acc, acc_d, sum;
    logic [2:0]      step_d, step_inc;
    logic [3:0]      trig_d, col_next, col_new;
    logic            bar_start_d;
    logic [7:0]      bpm_r;
    logic [3:0][7:0] shadow, active, active_d;
    always_comb begin
        sum         = acc + {24'd0, bpm_r};
        step_inc    = step + 3'd1;
        col_next    = '0;
        col_new     = '0;
        for (int i = 0; i < 4; i++) begin
            col_next[i] = active[i][step_inc];
            col_new[i]  = shadow[i][0];
        end
        state_d     = state;
        acc_d       = acc;
        step_d      = step;
        trig_d      = 4'd0;
        bar_start_d = 1'b0;
        active_d    = active;
        if (stop) begin
            state_d = IDLE;
            acc_d   = '0;
            step_d  = '0;
        end else if (state == IDLE) begin
            if (start) begin
                state_d     = RUN;
                acc_d       = '0;
                step_d      = '0;
                active_d    = shadow;
                trig_d      = col_new;
                bar_start_d = 1'b1;
            end
        end else if (state == PAUSE) begin
            state_d = start ? RUN : PAUSE;
        end else if (pause) begin
            state_d = PAUSE;
        end else if (sum >= THRESH) begin
            // Subtracting THRESH rather than clearing keeps the fractional phase, so no drift.
            acc_d  = sum - THRESH;
            step_d = step_inc;
            if (step_inc == 3'd0) begin
                active_d    = shadow;
                trig_d      = col_new;
                bar_start_d = 1'b1;
            end else begin
                trig_d = col_next;
            end
        end else begin
            acc_d = sum;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            acc       <= '0;
            step      <= '0;
            trig      <= '0;
            bar_start <= 1'b0;
            running   <= 1'b0;
            bpm_r     <= 8'(DEFAULT_BPM);
            shadow    <= '0;
            active    <= '0;
        end else begin
            state     <= state_d;
            acc       <= acc_d;
            step      <= step_d;
            trig      <= trig_d;
            bar_start <= bar_start_d;
            running   <= (state_d == RUN);
            active    <= active_d;
            bpm_r     <= ld_bpm ? bpm : bpm_r;
            if (pat_we) shadow[pat_sel] <= pat_data;
        end
    end
endmodule

// File: tb/tb_step_scheduler.sv
// tb_step_scheduler: directed tempo, pattern, pause and reset vectors for step_scheduler.
module tb_step_scheduler;
    logic       clk = 1'b0;
    logic       reset, ld_bpm, pat_we, start, pause, stop;
    logic [7:0] bpm, pat_data;
    logic [1:0] pat_sel;
    logic [3:0] trig;
    logic [2:0] step;
    logic       bar_start, running;
    int         n_vec = 0, n_bad = 0, cyc = 0, t_last = 0, t_start = 0, bad = 0;
    // Expected trig per step with snare=8'h44, kick=8'h11, hat/clap off.
    logic [3:0] base [8] = '{4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 4'b0000};

    step_scheduler #(.CLK_HZ(1200), .STEPS_PER_BEAT(2), .DEFAULT_BPM(120)) dut (
        .clk(clk), .reset(reset), .bpm(bpm), .ld_bpm(ld_bpm), .pat_sel(pat_sel),
        .pat_data(pat_data), .pat_we(pat_we), .start(start), .pause(pause), .stop(stop),
        .trig(trig), .step(step), .bar_start(bar_start), .running(running)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic write(input logic [1:0] sel, input logic [7:0] data);
        pat_sel = sel; pat_data = data; pat_we = 1'b1;
        cycle();
        pat_we = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        cycle();
        start = 1'b0;
        t_last = cyc;
    endtask

    task automatic step_check(input logic [2:0] es, input logic [3:0] et, input int eg);
        logic [2:0] s0;
        int t0;
        s0 = step;
        t0 = cyc;
        while (step == s0 && cyc - t0 < eg + 50) cycle();
        check("gap", cyc - t_last, eg);
        t_last = cyc;
        check("step", step, es);
        check("trig", trig, et);
        check("bar_start", bar_start, es == 3'd0);
    endtask

    initial begin
        reset = 1'b0; bpm = '0; ld_bpm = 0; pat_sel = '0; pat_data = '0;
        pat_we = 0; start = 0; pause = 0; stop = 0;
        #3;
        check("rst_trig", trig, 0);
        check("rst_step", step, 0);
        check("rst_running", running, 0);
        check("rst_bar", bar_start, 0);
        cycle(); cycle();
        reset = 1'b1;
        // basic bar at 120 bpm
        write(2'd1, 8'h11);
        write(2'd0, 8'h44);
        bpm = 8'd120; ld_bpm = 1; cycle(); ld_bpm = 0;
        go();
        check("t1_trig0", trig, 4'b0010);
        check("t1_bar0", bar_start, 1);
        check("t1_run", running, 1);
        check("t1_step0", step, 0);
        cycle();
        check("t1_quiet", trig, 0);
        check("t1_bar_quiet", bar_start, 0);
        for (int s = 1; s <= 8; s++) step_check(3'(s), base[s % 8], 300);
        // bpm 7: 6x5143 + 5142 = 36000
        stop = 1; bpm = 8'd7; ld_bpm = 1; cycle(); stop = 0; ld_bpm = 0;
        check("t2_stop_step", step, 0);
        check("t2_stop_run", running, 0);
        check("t2_stop_trig", trig, 0);
        go();
        t_start = cyc;
        for (int k = 1; k <= 7; k++) step_check(3'(k), base[k], (k == 7) ? 5142 : 5143);
        check("t2_total", cyc - t_start, 36000);
        // hat written mid-bar only plays after wrap
        stop = 1; bpm = 8'd120; ld_bpm = 1; cycle(); stop = 0; ld_bpm = 0;
        go();
        check("t3_trig0", trig, 4'b0010);
        step_check(3'd1, base[1], 300);
        step_check(3'd2, base[2], 300);
        write(2'd2, 8'hFF);
        for (int s = 3; s <= 7; s++) step_check(3'(s), base[s], 300);
        for (int s = 0; s <= 7; s++) step_check(3'(s), base[s] | 4'b0100, 300);
        // hat cleared exactly on the wrap tick: old pattern plays one more bar
        repeat (299) cycle();
        write(2'd2, 8'h00);
        check("t4_wrap_gap", cyc - t_last, 300);
        t_last = cyc;
        check("t4_wrap_step", step, 0);
        check("t4_wrap_trig", trig, 4'b0110);
        check("t4_wrap_bar", bar_start, 1);
        for (int s = 1; s <= 7; s++) step_check(3'(s), base[s] | 4'b0100, 300);
        for (int s = 0; s <= 3; s++) step_check(3'(s), base[s], 300);
        // pause at step 3 after 100 cycles of phase
        repeat (100) cycle();
        pause = 1; cycle(); pause = 0;
        check("t5_pause_run", running, 0);
        check("t5_pause_step", step, 3);
        check("t5_pause_trig", trig, 0);
        repeat (1000) begin
            cycle();
            if (trig != 4'd0 || step != 3'd3) bad++;
        end
        check("t5_paused_quiet", bad, 0);
        go();
        check("t5_resume_run", running, 1);
        check("t5_resume_trig", trig, 0);
        check("t5_resume_step", step, 3);
        step_check(3'd4, base[4], 200);
        start = 1; stop = 1; cycle(); start = 0; stop = 0;
        check("t5_ss_step", step, 0);
        check("t5_ss_run", running, 0);
        check("t5_ss_trig", trig, 0);
        // async reset right after a tick with trig in flight
        write(2'd3, 8'hFF);
        bpm = 8'd255; ld_bpm = 1; cycle(); ld_bpm = 0;
        go();
        check("t6_trig0", trig, 4'b1010);
        step_check(3'd1, 4'b1000, 142);
        #2 reset = 1'b0;
        #1;
        check("t6_rst_trig", trig, 0);
        check("t6_rst_step", step, 0);
        check("t6_rst_run", running, 0);
        check("t6_rst_bar", bar_start, 0);
        cycle(); cycle();
        reset = 1'b1;
        go();
        check("t6_trig_cleared", trig, 0);
        check("t6_bar", bar_start, 1);
        check("t6_run", running, 1);
        step_check(3'd1, 4'b0000, 300);
        bpm = 8'd0; ld_bpm = 1; cycle(); ld_bpm = 0;
        bad = 0;
        repeat (1000) begin
            cycle();
            if (step != 3'd1 || !running || trig != 4'd0) bad++;
        end
        check("t6_bpm0_hold", bad, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
